// File: rtl/mem_map_decoder.sv
// Memory-map decoder for the 8-bit CPU bus: RAM/ROM/IO chip selects plus per-region wait states.
// Optional ROM overlay control register is compiled in with `define ROM_OVERLAY_EN.
module mem_map_decoder #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [3:0]            IO_NIB     = 4'hD,
    parameter logic [3:0]            ROM_NIB    = 4'hE,
    parameter int                    IO_DEVICES = 8,
    parameter int                    RAM_WAIT   = 0,
    parameter int                    IO_WAIT    = 2,
    parameter int                    ROM_WAIT   = 1,
    parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR  = 'hDF00
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  bus_req,
    input  logic                  rw,
    input  logic [7:0]            data_in,
    output logic                  rdy,
    output logic                  ram_sel_n,
    output logic                  rom_sel_n,
    output logic                  io_sel_n,
    output logic [IO_DEVICES-1:0] io_dev_sel_n
);

    typedef enum logic [1:0] {
        REG_RAM,
        REG_IO,
        REG_ROM
    } region_t;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    localparam logic [3:0] RAM_W = 4'(RAM_WAIT);
    localparam logic [3:0] IO_W  = 4'(IO_WAIT);
    localparam logic [3:0] ROM_W = 4'(ROM_WAIT);

    state_t     state, state_nxt;
    region_t    lat_region;
    logic [3:0] lat_dev;
    logic [3:0] cnt;

    logic [3:0] nib;
    region_t    addr_region;
    logic [3:0] addr_wait;
    logic       ovl;

    region_t    sel_region;
    logic [3:0] sel_dev;
    logic       sel_active;

    assign nib = addr[ADDR_WIDTH-1 -: 4];

`ifdef ROM_OVERLAY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovl <= 1'b0;
        end else if (bus_req && rdy && !rw && (addr == CTRL_ADDR)) begin
            ovl <= data_in[0];
        end
    end
`else
    logic unused_inputs;
    assign ovl           = 1'b0;
    assign unused_inputs = &{1'b0, rw, data_in, addr[7:0], CTRL_ADDR};
`endif

    // With the overlay set, the ROM window is remapped onto RAM timing and selects
    always_comb begin
        if (nib == IO_NIB) begin
            addr_region = REG_IO;
        end else if ((nib >= ROM_NIB) && !ovl) begin
            addr_region = REG_ROM;
        end else begin
            addr_region = REG_RAM;
        end
        case (addr_region)
            REG_IO:  addr_wait = IO_W;
            REG_ROM: addr_wait = ROM_W;
            default: addr_wait = RAM_W;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            lat_region <= REG_RAM;
            lat_dev    <= '0;
        end else if (bus_req) begin
            if (state == ST_IDLE) begin
                if (addr_wait != 4'd0) begin
                    cnt        <= addr_wait - 4'd1;
                    lat_region <= addr_region;
                    lat_dev    <= addr[11:8];
                end
            end else if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end else begin
            cnt <= '0;
        end
    end

    // Selects are gated by reset_n so they drop immediately even if bus_req stays high
    always_comb begin
        state_nxt  = state;
        rdy        = 1'b0;
        sel_active = 1'b0;
        sel_region = addr_region;
        sel_dev    = addr[11:8];
        if (reset_n) begin
            case (state)
                ST_IDLE: begin
                    if (bus_req) begin
                        sel_active = 1'b1;
                        if (addr_wait == 4'd0) begin
                            rdy = 1'b1;
                        end else begin
                            state_nxt = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus_req) begin
                        sel_active = 1'b1;
                        sel_region = lat_region;
                        sel_dev    = lat_dev;
                        if (cnt == 4'd0) begin
                            rdy       = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ram_sel_n    = 1'b1;
        rom_sel_n    = 1'b1;
        io_sel_n     = 1'b1;
        io_dev_sel_n = '1;
        if (sel_active) begin
            case (sel_region)
                REG_IO:  io_sel_n  = 1'b0;
                REG_ROM: rom_sel_n = 1'b0;
                default: ram_sel_n = 1'b0;
            endcase
            if (sel_region == REG_IO) begin
                for (int unsigned i = 0; i < IO_DEVICES; i++) begin
                    if (sel_dev == i[3:0]) begin
                        io_dev_sel_n[i] = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_map_decoder.sv
// Directed-vector bench for mem_map_decoder with default parameters; overlay checks
// are included when ROM_OVERLAY_EN is defined.
module tb_mem_map_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] addr;
    logic        bus_req;
    logic        rw;
    logic [7:0]  data_in;
    logic        rdy;
    logic        ram_sel_n;
    logic        rom_sel_n;
    logic        io_sel_n;
    logic [7:0]  io_dev_sel_n;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_map_decoder #(
        .ADDR_WIDTH(16),
        .IO_DEVICES(8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .addr         (addr),
        .bus_req      (bus_req),
        .rw           (rw),
        .data_in      (data_in),
        .rdy          (rdy),
        .ram_sel_n    (ram_sel_n),
        .rom_sel_n    (rom_sel_n),
        .io_sel_n     (io_sel_n),
        .io_dev_sel_n (io_dev_sel_n)
    );

    typedef struct {
        logic        req;
        logic [15:0] a;
        logic        ram;
        logic        rom;
        logic        io;
        logic [7:0]  dev;
        logic        rdy;
    } vec_t;

    vec_t vecs[22];

    // Packed as {ram_sel_n, rom_sel_n, io_sel_n, io_dev_sel_n, rdy}
    task automatic check(input string name, input logic ram, input logic rom,
                         input logic io, input logic [7:0] dev, input logic r);
        logic [11:0] act, exp;
        act = {ram_sel_n, rom_sel_n, io_sel_n, io_dev_sel_n, rdy};
        exp = {ram, rom, io, dev, r};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got ram=%b rom=%b io=%b dev=%h rdy=%b, want ram=%b rom=%b io=%b dev=%h rdy=%b",
                     name, act[11], act[10], act[9], act[8:1], act[0],
                     ram, rom, io, dev, r);
        end
    endtask

    task automatic drive(input logic req, input logic [15:0] a, input logic w, input logic [7:0] d);
        @(posedge clk);
        #1;
        bus_req = req;
        addr    = a;
        rw      = ~w;
        data_in = d;
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0};
        vecs[1]  = '{1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1};
        vecs[2]  = '{1'b1, 16'hCFFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1};
        vecs[3]  = '{1'b1, 16'hD300, 1'b1, 1'b1, 1'b0, 8'hF7, 1'b0};
        vecs[4]  = '{1'b1, 16'hD300, 1'b1, 1'b1, 1'b0, 8'hF7, 1'b0};
        vecs[5]  = '{1'b1, 16'hD300, 1'b1, 1'b1, 1'b0, 8'hF7, 1'b1};
        vecs[6]  = '{1'b1, 16'hDA00, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0};
        vecs[7]  = '{1'b1, 16'hDA00, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0};
        vecs[8]  = '{1'b1, 16'hDA00, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1};
        vecs[9]  = '{1'b1, 16'hE000, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0};
        vecs[10] = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1};
        vecs[11] = '{1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1};
        vecs[12] = '{1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0};
        vecs[13] = '{1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1};
        vecs[14] = '{1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0};
        vecs[15] = '{1'b1, 16'hD000, 1'b1, 1'b1, 1'b0, 8'hFE, 1'b0};
        vecs[16] = '{1'b0, 16'hD000, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0};
        vecs[17] = '{1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1};
        vecs[18] = '{1'b1, 16'hD700, 1'b1, 1'b1, 1'b0, 8'h7F, 1'b0};
        vecs[19] = '{1'b1, 16'hD700, 1'b1, 1'b1, 1'b0, 8'h7F, 1'b0};
        vecs[20] = '{1'b1, 16'hD700, 1'b1, 1'b1, 1'b0, 8'h7F, 1'b1};
        vecs[21] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0};

        reset_n = 1'b0;
        bus_req = 1'b0;
        addr    = '0;
        rw      = 1'b1;
        data_in = '0;
        #12;
        check("reset_state", 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].req, vecs[i].a, 1'b0, 8'h00);
            check($sformatf("vec%0d", i), vecs[i].ram, vecs[i].rom, vecs[i].io,
                  vecs[i].dev, vecs[i].rdy);
        end

        // Reset asserted mid-WAIT of an IO access with bus_req still held
        drive(1'b1, 16'hD100, 1'b0, 8'h00);
        check("rst_io_start", 1'b1, 1'b1, 1'b0, 8'hFD, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_wait", 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);
        @(negedge clk);
        bus_req = 1'b0;
        reset_n = 1'b1;
        drive(1'b1, 16'h1234, 1'b0, 8'h00);
        check("rst_resume_ram", 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
        drive(1'b0, 16'h0000, 1'b0, 8'h00);

`ifdef ROM_OVERLAY_EN
        drive(1'b1, 16'hDF00, 1'b1, 8'h01);
        check("ovl_wr1_c1", 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
        drive(1'b1, 16'hDF00, 1'b1, 8'h01);
        drive(1'b1, 16'hDF00, 1'b1, 8'h01);
        check("ovl_wr1_c3", 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1);
        drive(1'b0, 16'h0000, 1'b0, 8'h00);
        drive(1'b1, 16'hF000, 1'b0, 8'h00);
        check("ovl_on_read", 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
        drive(1'b0, 16'h0000, 1'b0, 8'h00);
        drive(1'b1, 16'hDF00, 1'b1, 8'h00);
        drive(1'b1, 16'hDF00, 1'b1, 8'h00);
        drive(1'b1, 16'hDF00, 1'b1, 8'h00);
        check("ovl_wr0_c3", 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1);
        drive(1'b0, 16'h0000, 1'b0, 8'h00);
        drive(1'b1, 16'hF000, 1'b0, 8'h00);
        check("ovl_off_c1", 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);
        drive(1'b1, 16'hF000, 1'b0, 8'h00);
        check("ovl_off_c2", 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1);
        drive(1'b0, 16'h0000, 1'b0, 8'h00);
`else
        // Without the overlay, 0xDF00 is plain IO (device 15 is out of range) and ROM stays ROM
        drive(1'b1, 16'hDF00, 1'b1, 8'h01);
        drive(1'b1, 16'hDF00, 1'b1, 8'h01);
        drive(1'b1, 16'hDF00, 1'b1, 8'h01);
        check("ctrl_as_io", 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1);
        drive(1'b1, 16'hF000, 1'b0, 8'h00);
        check("rom_after_ctrl", 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);
        drive(1'b1, 16'hF000, 1'b0, 8'h00);
        drive(1'b0, 16'h0000, 1'b0, 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach end, want finish before 100000");
        $fatal(1);
    end

endmodule
